// File: rtl/bounce_squares.sv
// Multi-square bouncing animator: moves N_SQ squares once per frame and
// reports, per strobed pixel, whether a square covers the beam and which one.
module bounce_squares #(
  parameter int N_SQ      = 4,
  parameter int CORDW     = 10,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int Q_SIZE    = 32,
  parameter int MAX_SPEED = 4,
  localparam int IDW      = (N_SQ > 1) ? $clog2(N_SQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stb_pix,
  input  logic             frame_start,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic             de,
  input  logic             pause,
  output logic             draw,
  output logic [IDW-1:0]   draw_id,
  output logic             busy
);

  // stb_pix qualifies frame_start/sx/sy/de; a trigger accepted in IDLE raises
  // busy on the next cycle and busy stays high until the commit has happened.
  localparam int AW = CORDW + 1;
  localparam logic [AW-1:0] XMAX = AW'(H_RES - Q_SIZE);
  localparam logic [AW-1:0] YMAX = AW'(V_RES - Q_SIZE);
  localparam logic [AW-1:0] QS   = AW'(Q_SIZE);

  typedef enum logic [1:0] {IDLE, UPDATE, COMMIT} state_t;
  state_t state, state_next;
  logic [IDW-1:0] idx, idx_next;

  logic [CORDW-1:0] wx [N_SQ];
  logic [CORDW-1:0] wy [N_SQ];
  logic [CORDW-1:0] qx [N_SQ];
  logic [CORDW-1:0] qy [N_SQ];
  logic [N_SQ-1:0]  dxr, dyd;

  // {new direction, new position}; forward means right/down.
  function automatic logic [CORDW:0] move_axis(
    input logic [CORDW-1:0] p,
    input logic             fwd,
    input logic [AW-1:0]    s,
    input logic [AW-1:0]    pmax
  );
    logic [AW-1:0] pe;
    pe = {1'b0, p};
    if (fwd) begin
      if (pe + s >= pmax) return {1'b0, pmax[CORDW-1:0]};
      else                return {1'b1, CORDW'(pe + s)};
    end else begin
      if (pe <= s) return {1'b1, {CORDW{1'b0}}};
      else         return {1'b0, CORDW'(pe - s)};
    end
  endfunction

  logic [CORDW:0] mv_x [N_SQ];
  logic [CORDW:0] mv_y [N_SQ];

  always_comb begin
    for (int i = 0; i < N_SQ; i++) begin
      mv_x[i] = move_axis(wx[i], dxr[i], AW'((i % MAX_SPEED) + 1), XMAX);
      mv_y[i] = move_axis(wy[i], dyd[i], AW'((i % MAX_SPEED) + 1), YMAX);
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      IDLE: begin
        if (stb_pix && frame_start && !pause) begin
          state_next = UPDATE;
          idx_next   = '0;
        end
      end
      UPDATE: begin
        idx_next = idx + 1'b1;
        if (idx == IDW'(N_SQ - 1)) state_next = COMMIT;
      end
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      for (int i = 0; i < N_SQ; i++) begin
        wx[i]  <= CORDW'(i * Q_SIZE / 2);
        wy[i]  <= CORDW'(i * Q_SIZE / 2);
        qx[i]  <= CORDW'(i * Q_SIZE / 2);
        qy[i]  <= CORDW'(i * Q_SIZE / 2);
        dxr[i] <= 1'b1;
        dyd[i] <= ((i % 2) == 0);
      end
    end else begin
      state <= state_next;
      idx   <= idx_next;
      for (int i = 0; i < N_SQ; i++) begin
        if (state == UPDATE && idx == IDW'(i)) begin
          {dxr[i], wx[i]} <= mv_x[i];
          {dyd[i], wy[i]} <= mv_y[i];
        end
        // Drawing only ever sees the committed copy, so a frame never tears.
        if (state == COMMIT) begin
          qx[i] <= wx[i];
          qy[i] <= wy[i];
        end
      end
    end
  end

  logic [N_SQ-1:0] hit;
  logic            hit_any;
  logic [IDW-1:0]  hit_id;

  always_comb begin
    hit = '0;
    for (int i = 0; i < N_SQ; i++) begin
      hit[i] = de
            && ({1'b0, sx} >= {1'b0, qx[i]}) && ({1'b0, sx} < {1'b0, qx[i]} + QS)
            && ({1'b0, sy} >= {1'b0, qy[i]}) && ({1'b0, sy} < {1'b0, qy[i]} + QS);
    end
  end

  // Scan downwards so the lowest covering index is the one left standing.
  always_comb begin
    hit_any = 1'b0;
    hit_id  = '0;
    for (int i = N_SQ - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any = 1'b1;
        hit_id  = IDW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      draw    <= 1'b0;
      draw_id <= '0;
    end else if (stb_pix) begin
      draw    <= hit_any;
      draw_id <= hit_id;
    end
  end

endmodule
